// File: rtl/trng_pkg.sv
// Shared TRNG types and default constants for the entropy front end.
package trng_pkg;

  // Von Neumann debias state: no stored bit, or first bit of a pair held.
  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } db_state_e;

  localparam int DEF_SAMPLE_DIV = 4;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_REP_LIMIT  = 32;

endpackage

// File: rtl/ro_cell.sv
// One enable-gated ring oscillator followed by a 2-flop synchronizer
// into the clock domain. The hierarchy is kept so synthesis cannot
// collapse or optimise away the ring.
(* KEEP_HIERARCHY = "yes" *)
module ro_cell #(
  parameter int STAGES = 3,
  parameter int DELAY  = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic sync_bit
);

  logic ring [STAGES];
  logic meta;
  logic sync_q;

  // First stage is a NAND with enable, so the ring parks at 1 when disabled.
  assign #(DELAY) ring[0] = ~(enable & ring[STAGES-1]);

  for (genvar i = 1; i < STAGES; i++) begin : gen_stage
    assign #(DELAY) ring[i] = ~ring[i-1];
  end

  // Two-flop synchronizer, clocked every cycle regardless of enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old
      // values together, which is what forms a two-stage shift.
      meta   <= ring[STAGES-1];
      sync_q <= meta;
    end
  end

  assign sync_bit = sync_q;

endmodule

// File: rtl/ro_bank.sv
// Ring-oscillator entropy source: CHANNELS rings XOR-combined into one
// raw bit per sample period, optional von Neumann debiasing, packing into
// WORD_WIDTH-bit words on a valid/ready port, and a repetition-count
// health test that latches on a stuck source.
module ro_bank
  import trng_pkg::*;
#(
  parameter int CHANNELS   = 8,
  parameter int STAGES     = 3,
  parameter int DELAY      = 2,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  debias,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  health_fail,
  output logic                  overrun
);

  localparam int DIV_W = $clog2(SAMPLE_DIV + 1);
  localparam int CNT_W = $clog2(WORD_WIDTH + 1);
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  logic [CHANNELS-1:0]   chan;
  logic [DIV_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [REP_W-1:0]      rep_cnt;
  logic [WORD_WIDTH-1:0] acc;
  logic                  raw_q;
  logic                  half_bit;
  logic                  debias_q;
  db_state_e             state;

  logic                  tick;
  logic                  raw_nxt;
  logic [REP_W-1:0]      rep_nxt;
  logic                  trip;
  logic                  blocked;
  logic                  mode_change;
  logic                  emit;
  logic                  emit_bit;
  logic                  acc_full;
  logic                  out_free;
  logic [WORD_WIDTH-1:0] acc_shift;

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    ro_cell #(
      .STAGES (STAGES),
      .DELAY  (DELAY)
    ) u_cell (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .sync_bit (chan[g])
    );
  end

  // Sample tick, next raw bit, repetition count and the emitted-bit decision.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    tick        = enable && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    raw_nxt     = ^chan;
    mode_change = (debias != debias_q);
    rep_nxt     = REP_W'(1);
    emit        = 1'b0;
    emit_bit    = 1'b0;

    if (rep_cnt != '0 && raw_nxt == raw_q) begin
      rep_nxt = (rep_cnt == REP_W'(REP_LIMIT)) ? rep_cnt : rep_cnt + REP_W'(1);
    end
    trip    = tick && (rep_nxt == REP_W'(REP_LIMIT));
    blocked = health_fail || trip;

    if (tick && !mode_change) begin
      if (!debias) begin
        emit     = 1'b1;
        emit_bit = raw_nxt;
      end else if (state == HALF && half_bit != raw_nxt) begin
        // 01 emits 0, 10 emits 1: the emitted bit is the first of the pair.
        emit     = 1'b1;
        emit_bit = half_bit;
      end
    end

    acc_full  = (bit_cnt == CNT_W'(WORD_WIDTH));
    out_free  = !out_valid || out_ready;
    acc_shift = {acc[WORD_WIDTH-2:0], emit_bit};
  end

  // Sample divider: counts 0..SAMPLE_DIV-1 while enabled.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Last raw bit, saturating repetition count and sticky health failure.
  always_ff @(posedge clock) begin
    if (reset) begin
      raw_q       <= 1'b0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (tick) begin
      raw_q   <= raw_nxt;
      rep_cnt <= rep_nxt;
      if (trip) begin
        health_fail <= 1'b1;
      end
    end
  end

  // Von Neumann pair FSM; any mode change or disable abandons a half pair.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      half_bit <= 1'b0;
      debias_q <= 1'b0;
    end else begin
      debias_q <= debias;
      if (!enable || mode_change) begin
        state <= IDLE;
      end else if (tick && debias) begin
        case (state)
          IDLE: begin
            half_bit <= raw_nxt;
            state    <= HALF;
          end
          HALF:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Accumulator, output register and overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      bit_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (blocked) begin
        acc       <= '0;
        bit_cnt   <= '0;
        out_valid <= 1'b0;
      end else if (!enable || mode_change) begin
        acc     <= '0;
        bit_cnt <= '0;
      end else if (acc_full) begin
        // A full accumulator waits for the output register to free up.
        if (out_free) begin
          out_data  <= acc;
          out_valid <= 1'b1;
          if (emit) begin
            acc     <= acc_shift;
            bit_cnt <= CNT_W'(1);
          end else begin
            bit_cnt <= '0;
          end
        end else if (emit) begin
          overrun <= 1'b1;
        end
      end else if (emit) begin
        // The last bit of a word goes straight to the output when possible,
        // so out_valid rises the cycle after the completing tick.
        if (bit_cnt == CNT_W'(WORD_WIDTH - 1) && out_free) begin
          out_data  <= acc_shift;
          out_valid <= 1'b1;
          bit_cnt   <= '0;
        end else begin
          acc     <= acc_shift;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/ro_bank.md
# ro_bank

Parametrised ring-oscillator entropy source: an array of `CHANNELS` independent ring oscillators, each resynchronised into the `clock` domain. Channel outputs are XOR-combined into one raw bit per sample period. Raw bits are optionally von Neumann debiased and packed into `WORD_WIDTH`-bit words delivered over a valid/ready interface. A repetition-count health test flags a stuck source. The block is the entropy front end of the TRNG and feeds the conditioning/post-processing stage.

## Interface
Parameters:
- `CHANNELS`, 8: number of ring oscillators; ≥1.
- `STAGES`, 3: inverting stages per ring; odd, ≥3.
- `DELAY`, 2: simulation gate delay per stage (time units).
- `SAMPLE_DIV`, 4: clocks per raw-bit sample; ≥2.
- `WORD_WIDTH`, 32: output word width; ≥2.
- `REP_LIMIT`, 32: consecutive identical raw bits that trip the health test; ≥2.

Ports:
- `clock`, in, 1: single clock. All logic is synchronous to it except the rings themselves.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: runs the rings and the sampling pipeline.
- `debias`, in, 1: 1 selects von Neumann mode; 0 selects raw mode.
- `out_data`, out, `WORD_WIDTH`: completed entropy word.
- `out_valid`, out, 1: `out_data` holds an unconsumed word.
- `out_ready`, in, 1: consumer accepts the word on `out_valid && out_ready`.
- `health_fail`, out, 1: sticky repetition-count failure.
- `overrun`, out, 1: sticky flag; at least one bit was dropped because both word buffers were full.

## Operation
- **Rings:** Each ring is gated by `enable`; the first stage is a NAND of `enable` and the feedback. With `enable` low, every ring parks at a static level.
- **Sync:** Each channel passes through a 2-flop synchronizer, clocked every cycle.
- **Divider:** Counts 0..`SAMPLE_DIV`-1 while `enable` is high. It issues a tick when the count equals `SAMPLE_DIV`-1, then wraps to 0.
- **Raw bit:** On a tick, `raw` <= XOR of all synchronized channels.
- **Raw mode:** Every raw bit is emitted.
- **Debias mode:**
  - States: `IDLE` (no stored bit) and `HALF` (first bit of a pair stored).
  - In `HALF`, the second bit resolves the pair: 01 emits 0, 10 emits 1, 00 and 11 emit nothing. The state then returns to `IDLE`.
- **Accumulator:** Each emitted bit shifts in MSB-first: `acc <= {acc[W-2:0], bit}`, with `bit_cnt` incremented. When `bit_cnt` reaches `WORD_WIDTH`, the accumulator is full.
  - If the output register is empty, or is being accepted in the same cycle, `acc` is transferred to `out_data`. `out_valid` is set and `bit_cnt` returns to 0.
  - Otherwise the accumulator holds. Further emitted bits are dropped and `overrun` is set. The transfer happens on the first cycle the output register frees.
- **Health:**
  - `rep_cnt` counts consecutive identical raw bits, measured before debiasing. It restarts at 1 on a change.
  - When `rep_cnt` reaches `REP_LIMIT`, `health_fail` is set.
  - While `health_fail` is 1: `out_valid` is forced to 0, the accumulator and `bit_cnt` are cleared, and no word is produced until `reset`.
- **`enable` deasserted:** The divider, the debias state (to `IDLE`) and `bit_cnt` are cleared. The partial word is discarded. `out_data`/`out_valid`, `rep_cnt`, the last raw bit and the sticky flags are retained.
- **`debias` change:** Switching mode is only legal with `enable` low. Any change of `debias` clears the debias state to `IDLE` and clears `bit_cnt`.

## Timing
- **Reset values:** `out_data`=0, `out_valid`=0, `health_fail`=0, `overrun`=0. Internally, the divider, `bit_cnt`, `rep_cnt`, the debias state and the sync flops are all 0.
- **Reset priority:** Reset mid-word drops all state. Reset wins over `enable` and over handshakes.
- **Sample latency:** A ring edge reaches the raw bit after 2–3 clocks of synchronizer delay plus the wait to the next tick.
- **Word completion:** `out_valid` rises the cycle after the tick that supplies the `WORD_WIDTH`-th emitted bit.
- **Handshake:** `out_valid`/`out_data` are stable until accepted. An accept and a new transfer in the same cycle keep `out_valid`=1 with the new data, with no bubble.
- **Minimum word period:** `WORD_WIDTH*SAMPLE_DIV` clocks in raw mode.
- **Counter widths:** `$clog2(X+1)`. No counter may wrap silently: `rep_cnt` saturates at `REP_LIMIT`.

## Structure
- Shared package `trng_pkg`: the debias state enum (`IDLE`, `HALF`) and default constants for `SAMPLE_DIV`, `WORD_WIDTH` and `REP_LIMIT`.
- Sub-module `ro_cell`: one enable-gated ring of `STAGES` stages with `DELAY`, plus its 2-flop synchronizer. It outputs a synchronized bit and carries `KEEP_HIERARCHY` so synthesis does not collapse the ring.
- `ro_bank` instantiates `CHANNELS` copies of `ro_cell` in a generate loop. It contains the divider, the debias FSM, the accumulator/output register and the health logic.

## Test plan
In all scenarios the bench forces the `ro_cell` outputs hierarchically so that the raw-bit sequences are deterministic.
1. **Reset/idle:** Assert `reset` with `enable`=0 → all outputs 0. No `out_valid` ever appears.
2. **Raw pack:** `WORD_WIDTH`=8, `SAMPLE_DIV`=4, `debias`=0, raw sequence 1,0,1,1,0,0,1,0 with `out_ready`=1 → `out_data`=8'hB2 and `out_valid` high one cycle after the 8th tick.
3. **Debias:** Pairs 01,10,11,00,10,… with `debias`=1 → emitted stream 0,1,1,…. Equal pairs are absent and `bit_cnt` advances only on unequal pairs.
4. **Backpressure:** `out_ready`=0 across two full words → the first word is held stable and the accumulator stalls. Subsequent bits are dropped with `overrun`=1. Raising `out_ready` → the second word follows with no bubble.
5. **Health:** Force all channels so that raw is constant 1 for `REP_LIMIT`=32 ticks → `health_fail`=1 on tick 32. `out_valid` drops to 0, and only `reset` clears the flag.
6. **Enable drop mid-word:** 5 of 8 bits collected, then `enable`=0 for 3 clocks, then re-enable → the next word contains only new bits. The previously held `out_data` is unchanged.
